instr_fetch_seq: RTL and testbench

//   Instruction sequencer for the 8-bit accumulator CPU: owns PC and IR, fetches from the shared

---
 rtl/instr_fetch_seq_if.sv | 46 ++++
 rtl/instr_fetch_seq.sv | 110 +++++++++++
 tb/tb_instr_fetch_seq.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_seq_if.sv
// ============================================================================
// Module : instr_fetch_seq_if
// Brief  : Memory and controller bundle for the instruction sequencer.
//          SINGLE_STEP_EN adds the step input.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instr_fetch_seq_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] mem_rdata;
   logic              jump;
   logic              skip;
   logic              Halt;
   logic              acc_zero;
`ifdef SINGLE_STEP_EN
   logic              step;
`endif
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_fetch;
   logic [2:0]        opcode;
   logic [ADDR_W-1:0] operand;
   logic              exec;
   logic [ADDR_W-1:0] pc;
   logic              halted;

   modport master (
`ifdef SINGLE_STEP_EN
      input  step,
`endif
      input  mem_rdata, jump, skip, Halt, acc_zero,
      output mem_addr, mem_fetch, opcode, operand, exec, pc, halted
   );

   modport slave (
`ifdef SINGLE_STEP_EN
      output step,
`endif
      output mem_rdata, jump, skip, Halt, acc_zero,
      input  mem_addr, mem_fetch, opcode, operand, exec, pc, halted
   );
endinterface

`default_nettype wire

// File: rtl/instr_fetch_seq.sv
// ============================================================================
// Module : instr_fetch_seq
// Brief  : PC/IR owner and 4-cycle fetch/load/decode/exec sequencer.
//          SINGLE_STEP_EN adds a step-gated pause state after each instruction.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_seq #(
   parameter int ADDR_W   = 5,
   parameter int DATA_W   = 8,
   parameter int RESET_PC = 0
) (
   input wire clk,
   input wire rst,
   instr_fetch_seq_if.master bus
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_LOAD   = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_HALT   = 3'd4,
      S_PAUSE  = 3'd5
   } state_t;

   localparam logic [ADDR_W-1:0] c_reset_pc = ADDR_W'(RESET_PC);
   localparam logic [ADDR_W-1:0] c_pc_one   = ADDR_W'(1);
`ifdef SINGLE_STEP_EN
   localparam state_t c_start_state = S_PAUSE;
   localparam state_t c_after_exec  = S_PAUSE;
`else
   localparam state_t c_start_state = S_FETCH;
   localparam state_t c_after_exec  = S_FETCH;
`endif

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] w_pc_nxt;
   logic [DATA_W-1:0] r_ir;
   logic [DATA_W-1:0] w_ir_nxt;
   logic [ADDR_W-1:0] w_operand;
   logic [ADDR_W-1:0] w_pc_inc;

   assign w_operand = r_ir[ADDR_W-1:0];
   assign w_pc_inc  = r_pc + c_pc_one;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= c_start_state;
         r_pc    <= c_reset_pc;
         r_ir    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_ir    <= w_ir_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_ir_nxt    = r_ir;
      case (r_state)
         S_FETCH:  w_state_nxt = S_LOAD;
         S_LOAD: begin
            w_ir_nxt    = bus.mem_rdata;
            w_pc_nxt    = w_pc_inc;
            w_state_nxt = S_DECODE;
         end
         S_DECODE: w_state_nxt = S_EXEC;
         S_EXEC: begin
            // Exactly one next-PC action: Halt, then jump, then taken skip.
            if (bus.Halt) begin
               w_state_nxt = S_HALT;
            end else begin
               if (bus.jump) begin
                  w_pc_nxt = w_operand;
               end else if (bus.skip && bus.acc_zero) begin
                  w_pc_nxt = w_pc_inc;
               end
               w_state_nxt = c_after_exec;
            end
         end
         S_HALT:   w_state_nxt = S_HALT;
`ifdef SINGLE_STEP_EN
         S_PAUSE: begin
            if (bus.step) begin
               w_state_nxt = S_FETCH;
            end
         end
`endif
         default:  w_state_nxt = c_start_state;
      endcase
   end

   // Memory address is the PC only while fetching; otherwise it serves operand reads.
   assign bus.mem_addr  = (r_state == S_FETCH) ? r_pc : w_operand;
   assign bus.mem_fetch = (r_state == S_FETCH);
   assign bus.exec      = (r_state == S_EXEC);
   assign bus.halted    = (r_state == S_HALT);
   assign bus.opcode    = r_ir[DATA_W-1 -: 3];
   assign bus.operand   = w_operand;
   assign bus.pc        = r_pc;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_seq.sv
// ============================================================================
// Module : tb_instr_fetch_seq
// Brief  : Directed bench for instr_fetch_seq with a registered-read memory.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_seq;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;
   logic [7:0] mem [0:31];

   always #5 clk = ~clk;

   instr_fetch_seq_if #(.ADDR_W(5), .DATA_W(8)) bus ();

   instr_fetch_seq #(
      .ADDR_W   (5),
      .DATA_W   (8),
      .RESET_PC (0)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always @(posedge clk) bus.mem_rdata <= mem[bus.mem_addr];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_ctrl(input logic j, input logic s, input logic h, input logic az);
      bus.jump     = j;
      bus.skip     = s;
      bus.Halt     = h;
      bus.acc_zero = az;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      set_ctrl(1'b0, 1'b0, 1'b0, 1'b0);
      tick;
      tick;
      rst = 1'b0;
`ifdef SINGLE_STEP_EN
      check_eq("rst_pause", 32'(bus.mem_fetch), 32'd0);
      tick;
`endif
      check_eq("rst_fetch", 32'(bus.mem_fetch), 32'd1);
      check_eq("rst_addr", 32'(bus.mem_addr), 32'd0);
      check_eq("rst_pc", 32'(bus.pc), 32'd0);
      check_eq("rst_opcode", 32'(bus.opcode), 32'd0);
      check_eq("rst_operand", 32'(bus.operand), 32'd0);
      check_eq("rst_exec", 32'(bus.exec), 32'd0);
      check_eq("rst_halted", 32'(bus.halted), 32'd0);
   endtask

   // Starts in S_FETCH at addr; ends in S_FETCH (or S_HALT) with pc expected at exp_pc.
   task automatic run_instr(input logic [4:0] addr, input logic [7:0] word,
                            input logic j, input logic s, input logic h, input logic az,
                            input logic [4:0] exp_pc);
      logic [4:0] pc_inc;
      pc_inc = addr + 5'd1;
      check_eq("fetch_strobe", 32'(bus.mem_fetch), 32'd1);
      check_eq("fetch_addr", 32'(bus.mem_addr), 32'(addr));
      mem[addr] = word;
      tick;
      check_eq("load_exec", 32'(bus.exec), 32'd0);
      check_eq("load_strobe", 32'(bus.mem_fetch), 32'd0);
      tick;
      check_eq("dec_opcode", 32'(bus.opcode), 32'(word[7:5]));
      check_eq("dec_operand", 32'(bus.operand), 32'(word[4:0]));
      check_eq("dec_addr", 32'(bus.mem_addr), 32'(word[4:0]));
      check_eq("dec_pc", 32'(bus.pc), 32'(pc_inc));
      check_eq("dec_exec", 32'(bus.exec), 32'd0);
      tick;
      check_eq("exec_flag", 32'(bus.exec), 32'd1);
      check_eq("exec_opcode", 32'(bus.opcode), 32'(word[7:5]));
      set_ctrl(j, s, h, az);
      tick;
      set_ctrl(1'b0, 1'b0, 1'b0, 1'b0);
      if (h) begin
         check_eq("halt_flag", 32'(bus.halted), 32'd1);
         check_eq("halt_strobe", 32'(bus.mem_fetch), 32'd0);
         check_eq("halt_exec", 32'(bus.exec), 32'd0);
         check_eq("halt_pc", 32'(bus.pc), 32'(exp_pc));
      end else begin
`ifdef SINGLE_STEP_EN
         check_eq("pause_strobe", 32'(bus.mem_fetch), 32'd0);
         tick;
`endif
         check_eq("next_pc", 32'(bus.pc), 32'(exp_pc));
         check_eq("next_addr", 32'(bus.mem_addr), 32'(exp_pc));
         check_eq("next_exec", 32'(bus.exec), 32'd0);
         check_eq("next_halted", 32'(bus.halted), 32'd0);
      end
   endtask

   initial begin
      int exec_cnt;
      for (int i = 0; i < 32; i++) mem[i] = 8'h00;
      set_ctrl(1'b0, 1'b0, 1'b0, 1'b0);
`ifdef SINGLE_STEP_EN
      bus.step = 1'b1;
`endif
      do_reset;

      // Sequential fetch, then jumps, skips and wrap-around.
      run_instr(5'd0,  8'h23, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1);
      run_instr(5'd1,  8'h41, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2);
      run_instr(5'd2,  8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 5'd17);
      run_instr(5'd17, 8'h09, 1'b1, 1'b1, 1'b0, 1'b1, 5'd9);
      run_instr(5'd9,  8'h03, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3);
      run_instr(5'd3,  8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 5'd5);
      run_instr(5'd5,  8'h03, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3);
      run_instr(5'd3,  8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 5'd4);
      run_instr(5'd4,  8'h1E, 1'b1, 1'b0, 1'b0, 1'b0, 5'd30);
      run_instr(5'd30, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0);
      run_instr(5'd0,  8'h1F, 1'b1, 1'b0, 1'b0, 1'b0, 5'd31);
      run_instr(5'd31, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      run_instr(5'd0,  8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1);
      run_instr(5'd1,  8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1);
      run_instr(5'd1,  8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1);

      // Reset asserted in the middle of S_DECODE takes effect immediately.
      mem[1] = 8'hE5;
      tick;
      tick;
      check_eq("pre_rst_opcode", 32'(bus.opcode), 32'd7);
      rst = 1'b1;
      #1;
      check_eq("mid_rst_pc", 32'(bus.pc), 32'd0);
      check_eq("mid_rst_opcode", 32'(bus.opcode), 32'd0);
      check_eq("mid_rst_operand", 32'(bus.operand), 32'd0);
      check_eq("mid_rst_exec", 32'(bus.exec), 32'd0);
      check_eq("mid_rst_halted", 32'(bus.halted), 32'd0);
      do_reset;

      // Halt beats a simultaneous jump and then freezes everything.
      run_instr(5'd0, 8'hA7, 1'b1, 1'b0, 1'b1, 1'b0, 5'd1);
      set_ctrl(1'b1, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 100; i++) begin
         tick;
         check_eq("hold_pc", 32'(bus.pc), 32'd1);
         check_eq("hold_halted", 32'(bus.halted), 32'd1);
         check_eq("hold_strobe", 32'(bus.mem_fetch), 32'd0);
      end
      check_eq("hold_opcode", 32'(bus.opcode), 32'd5);
      do_reset;
      run_instr(5'd0, 8'h23, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1);

`ifdef SINGLE_STEP_EN
      // With step low the sequencer parks; a single step pulse yields one instruction.
      bus.step = 1'b0;
      mem[2] = 8'h00;
      for (int i = 0; i < 4; i++) tick;
      for (int i = 0; i < 10; i++) begin
         tick;
         check_eq("park_strobe", 32'(bus.mem_fetch), 32'd0);
         check_eq("park_exec", 32'(bus.exec), 32'd0);
      end
      bus.step = 1'b1;
      tick;
      bus.step = 1'b0;
      exec_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         if (bus.exec) exec_cnt++;
         tick;
      end
      check_eq("step_exec_count", 32'(exec_cnt), 32'd1);
      check_eq("step_pc", 32'(bus.pc), 32'd3);
`else
      exec_cnt = 0;
      for (int i = 0; i < 16; i++) begin
         if (bus.exec) exec_cnt++;
         tick;
      end
      check_eq("free_exec_count", 32'(exec_cnt), 32'd4);
      check_eq("free_pc", 32'(bus.pc), 32'd5);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
